ram_port_arb: RTL

Round-robin arbiter that shares the single-port RAM (port A) between three requesters: CPU data side, serial loader and debug dumper. It replaces the per-state address/data muxing at the top level with request/grant handshakes, so the requesters can run concurrently. Each requester may issue one word access per granted cycle. The block tags every read and routes the returned word back to the requester that issued it.

---
 rtl/ram_port_arb.sv | 89 ++++++++
 1 files changed

// File: rtl/ram_port_arb.sv
// Round-robin arbiter that shares one single-port RAM among three requesters.
// Read returns are routed back to their issuer through a tag pipeline.
module ram_port_arb #(
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req,
  input  logic [3*ADDR_BITS-1:0]   addr,
  input  logic [11:0]              byteen,
  input  logic [95:0]              wrdata,
  input  logic [2:0]               wren,
  input  logic                     freeze,
  output logic [2:0]               gnt,
  output logic [2:0]               rvalid,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic [ADDR_BITS-1:0]     ram_addr,
  output logic [3:0]               ram_byteen,
  output logic [31:0]              ram_wrdata,
  output logic                     ram_wren,
  input  logic [31:0]              ram_rddata
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DEPTH  = RD_LAT + 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic [1:0]             ptr;
  logic [1:0]             win_idx;
  logic                   accept;
  logic [2:0]             cand;
  logic [DEPTH-1:0][2:0]  tag;

  // Priority search starting at ptr; freeze and reset suppress all grants.
  always_comb begin
    gnt     = 3'b000;
    win_idx = 2'd0;
    accept  = 1'b0;
    cand    = 3'd0;
    if (rst && !freeze) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        cand = {1'b0, ptr} + 3'(k);
        if (cand >= 3'd3) cand = cand - 3'd3;
        if (!accept && req[cand[1:0]]) begin
          accept  = 1'b1;
          win_idx = cand[1:0];
        end
      end
      if (accept) gnt = 3'b001 << win_idx;
    end
  end

  // Command register towards the RAM and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= 2'd0;
      ram_addr   <= '0;
      ram_byteen <= '0;
      ram_wrdata <= '0;
      ram_wren   <= 1'b0;
    end else if (accept) begin
      ram_addr   <= addr[int'(win_idx)*ADDR_BITS +: ADDR_BITS];
      ram_byteen <= byteen[int'(win_idx)*BE_W +: BE_W];
      ram_wrdata <= wrdata[int'(win_idx)*DATA_W +: DATA_W];
      ram_wren   <= wren[win_idx];
      ptr        <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end else begin
      ram_wren   <= 1'b0;
    end
  end

  // Tags are carried one-hot, so the last stage is the rvalid strobe itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag <= '0;
    end else begin
      tag[0] <= (accept && !wren[win_idx]) ? gnt : 3'b000;
      for (int s = 1; s < int'(DEPTH); s++) tag[s] <= tag[s-1];
    end
  end

  assign rvalid = tag[DEPTH-1];
  assign busy   = |tag;
  assign rdata  = ram_rddata;

endmodule
